// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: bundle of the request/data/grant signals shared between N requesters,
// the round-robin mux arbiter and the downstream consumer.
//   req       N     per-requester level request
//   data_in   N*W   concatenated requester data, slice i = [i*W +: W]
//   out_ready 1     downstream accepts out_data this cycle
//   gnt       N     registered one-hot grant
//   sel       log2N registered mux select (index of the gnt bit)
//   out_valid 1     selected slice is valid on out_data
//   out_data  W     muxed data
//   busy      1     an owner currently holds the mux
// Modports: master = requester/consumer side, slave = arbiter side.
interface mux_rr_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) ();
    localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N*W-1:0]  data_in;
    logic            out_ready;
    logic [N-1:0]    gnt;
    logic [SelW-1:0] sel;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            busy;

    modport master (
        output req,
        output data_in,
        output out_ready,
        input  gnt,
        input  sel,
        input  out_valid,
        input  out_data,
        input  busy
    );

    modport slave (
        input  req,
        input  data_in,
        input  out_ready,
        output gnt,
        output sel,
        output out_valid,
        output out_data,
        output busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: N-way round-robin arbiter with an N:1 data mux and a hold limit.
// An idle arbiter grants the first requester at or after a rotating pointer; the owner
// keeps the mux until it drops its request or, while others wait, has held it MAX_HOLD
// cycles. Every handoff passes through one idle cycle. gnt/sel come straight from flops.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   bus  mux_rr_arbiter_if slave modport (req, data_in, out_ready in; gnt, sel,
//        out_valid, out_data, busy out)
module mux_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic            clk,
    input logic            rst,
    mux_rr_arbiter_if.slave bus
);
    localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [SelW-1:0] sel_q, sel_d;
    logic [SelW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [SelW-1:0] pick;
    logic [SelW-1:0] sel_inc;
    logic            found;
    logic            req_sel;
    logic            others;
    logic            hold_done;
    int unsigned     idx;

    // The arbiter never looks at out_ready: backpressure must not alter ownership.
    logic unused_out_ready;
    assign unused_out_ready = bus.out_ready;

    // First requester at or after ptr, searching upward modulo N.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_q) + i) % N;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = SelW'(idx);
            end
        end
    end

    always_comb begin
        req_sel = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_q == SelW'(i)) begin
                req_sel = bus.req[i];
            end
        end
    end

    assign sel_inc   = (sel_q == SelW'(N - 1)) ? '0 : sel_q + 1'b1;
    // gnt_q is one-hot on the owner, so this flags any waiting requester.
    assign others    = |(bus.req & ~gnt_q);
    // Counter saturates at MAX_HOLD, so >= keeps preemption armed after saturation.
    assign hold_done = (cnt_q >= CntW'(MAX_HOLD - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_q <= '0;
            sel_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            sel_q <= sel_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGrant;
                    sel_d   = pick;
                    gnt_d   = N'(1) << pick;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                if (!req_sel || (hold_done && others)) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    ptr_d   = sel_inc;
                end else if (cnt_q != CntW'(MAX_HOLD)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.gnt       = gnt_q;
        bus.sel       = sel_q;
        bus.busy      = (state_q == StGrant);
        bus.out_valid = (state_q == StGrant) && req_sel;
        bus.out_data  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_q == SelW'(i)) begin
                bus.out_data = bus.data_in[i*W +: W];
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized traffic, all outputs compared
// every cycle against a behavioural owner/pointer/hold-count model.
module tb_mux_rr_arbiter;
    localparam int unsigned N       = 4;
    localparam int unsigned W       = 8;
    localparam int unsigned MaxHold = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.N(N), .W(W)) bus ();

    mux_rr_arbiter #(.N(N), .W(W), .MAX_HOLD(MaxHold)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: owner index (-1 = nobody), last select, rotating pointer, cycles held so far.
    int m_owner = -1;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_held  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] slice_of(input int i);
        return bus.data_in[i*W +: W];
    endfunction

    task automatic check_outputs();
        logic [N-1:0] eg;
        logic         ev;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        ev = (m_owner >= 0) && bus.req[m_sel];
        check_eq("gnt", 32'(bus.gnt), 32'(eg));
        check_eq("sel", 32'(bus.sel), 32'(m_sel));
        check_eq("busy", 32'(bus.busy), 32'(m_owner >= 0));
        check_eq("out_valid", 32'(bus.out_valid), 32'(ev));
        check_eq("out_data", 32'(bus.out_data), 32'(slice_of(m_sel)));
    endtask

    task automatic model_edge();
        logic others;
        if (!rst) begin
            m_owner = -1;
            m_sel   = 0;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < int'(N); i++) begin
                if (m_owner < 0 && bus.req[(m_ptr + i) % N]) begin
                    m_owner = (m_ptr + i) % N;
                end
            end
            if (m_owner >= 0) begin
                m_sel  = m_owner;
                m_held = 0;
            end
        end else begin
            others = |(bus.req & ~(N'(1) << m_owner));
            if (!bus.req[m_owner] || (m_held + 1 >= int'(MaxHold) && others)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (m_held < int'(MaxHold)) begin
                m_held++;
            end
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are checked mid-cycle.
    task automatic tick();
        #2;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    logic [N-1:0] g_hist [0:11];

    initial begin
        bus.req       = '0;
        bus.data_in   = 32'h44332211;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // All quiet after reset.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("quiet_gnt", 32'(bus.gnt), 32'h0);
            check_eq("quiet_valid", 32'(bus.out_valid), 32'h0);
        end

        // req 1010 -> owner 1, then handoff to 3 through one idle cycle.
        bus.req = 4'b1010;
        tick();
        check_eq("r32_gnt1", 32'(bus.gnt), 32'b0010);
        check_eq("r32_sel1", 32'(bus.sel), 32'd1);
        check_eq("r32_data", 32'(bus.out_data), 32'h22);
        bus.req = 4'b1000;
        tick();
        check_eq("r32_gap", 32'(bus.gnt), 32'h0);
        tick();
        check_eq("r32_gnt3", 32'(bus.gnt), 32'b1000);
        check_eq("r32_sel3", 32'(bus.sel), 32'd3);

        // Owner 3 gives up (hold limit) with 0 waiting: pointer wraps to 0.
        bus.req = 4'b1001;
        for (int i = 0; i < 10 && bus.gnt != '0; i++) tick();
        check_eq("r33_release", 32'(bus.gnt), 32'h0);
        tick();
        check_eq("r33_wrap", 32'(bus.gnt), 32'b0001);
        bus.req = '0;
        tick();
        tick();

        // Hold-limit preemption ping-pong between 0 and 1.
        do_reset();
        bus.req = 4'b0011;
        for (int k = 1; k <= 11; k++) begin
            tick();
            g_hist[k] = bus.gnt;
        end
        check_eq("r34_c1", 32'(g_hist[1]), 32'b0001);
        check_eq("r34_c4", 32'(g_hist[4]), 32'b0001);
        check_eq("r34_idle1", 32'(g_hist[5]), 32'h0);
        check_eq("r34_c6", 32'(g_hist[6]), 32'b0010);
        check_eq("r34_c9", 32'(g_hist[9]), 32'b0010);
        check_eq("r34_idle2", 32'(g_hist[10]), 32'h0);
        check_eq("r34_back", 32'(g_hist[11]), 32'b0001);

        // Backpressure does not disturb owner 2.
        do_reset();
        bus.req       = 4'b0100;
        bus.data_in   = 32'h00A50000;
        bus.out_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("r35_valid", 32'(bus.out_valid), 32'h1);
            check_eq("r35_data", 32'(bus.out_data), 32'hA5);
            check_eq("r35_gnt", 32'(bus.gnt), 32'b0100);
        end
        bus.out_ready = 1'b1;

        // Reset mid-grant, then pointer restarts at 0.
        do_reset();
        bus.req = 4'b0010;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_eq("r36_gnt", 32'(bus.gnt), 32'h0);
        check_eq("r36_sel", 32'(bus.sel), 32'h0);
        rst     = 1'b1;
        bus.req = 4'b0110;
        tick();
        check_eq("r36_regrant", 32'(bus.gnt), 32'b0010);

        // Random traffic: sticky requests, random data/ready, rare resets.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < int'(N); b++) begin
                if ($urandom_range(0, 7) == 0) bus.req[b] = ~bus.req[b];
            end
            bus.data_in   = $urandom;
            bus.out_ready = 1'($urandom);
            rst           = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
